// File: rtl/irq_pkg.sv
// Shared constants for the interrupt/preemption controller: config opcodes,
// arbiter state encoding and pending-vector bit positions.
package irq_pkg;

    localparam logic [3:0] CFG_NOP         = 4'd0;
    localparam logic [3:0] CFG_SET_QUANTUM = 4'd1;
    localparam logic [3:0] CFG_SET_TVEC    = 4'd2;
    localparam logic [3:0] CFG_SET_KVEC    = 4'd3;
    localparam logic [3:0] CFG_TIMER_ON    = 4'd4;
    localparam logic [3:0] CFG_TIMER_OFF   = 4'd5;
    localparam logic [3:0] CFG_KEY_MASK    = 4'd6;
    localparam logic [3:0] CFG_CLR_PEND    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_SETTLE  = 2'd2
    } arb_state_t;

    // Timer owns bit 0 (highest priority); key i owns bit PEND_KEY0 + i.
    localparam int unsigned PEND_TIMER = 0;
    localparam int unsigned PEND_KEY0  = 1;

endpackage

// File: rtl/key_edge_sync.sv
// One board key: two-flop synchronizer plus a delayed copy for falling-edge
// detection. fall_c is a one-cycle pulse, combinational from flops.
module key_edge_sync (
    input  logic clock,
    input  logic n_reset,
    input  logic key_n,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchronizer chain; idles high so an unpressed key never pulses.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            meta   <= key_n;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign fall_c = sync_d & ~sync;

endmodule

// File: rtl/irq_preempt_ctrl.sv
// Interrupt and preemption controller: user-mode quantum timer, key event
// capture, pending vector and a one-at-a-time arbiter feeding the PC.
module irq_preempt_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned              QUANTUM_W     = 16,
    parameter logic [QUANTUM_W-1:0]     DEF_QUANTUM   = 16'd1000,
    parameter logic [15:0]              DEF_TIMER_VEC = 16'h0010,
    parameter logic [15:0]              DEF_KEY_VEC   = 16'h0020,
    parameter int unsigned              NKEYS         = 4
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             cfg_en,
    input  logic [3:0]       cfg_op,
    input  logic [15:0]      cfg_value,
    input  logic [NKEYS-1:0] keys_n,
    input  logic             kernel_mode,
    input  logic             int_ack,
    output logic             timer_int,
    output logic             op_int,
    output logic [15:0]      int_pos,
    output logic [NKEYS:0]   pending
);

    localparam int unsigned NPEND = NKEYS + 1;
    localparam int unsigned SEL_W = $clog2(NPEND);

    logic [QUANTUM_W-1:0] quantum;
    logic [QUANTUM_W-1:0] counter;
    logic [15:0]          timer_vec;
    logic [15:0]          key_vec;
    logic                 timer_en;
    logic [NKEYS-1:0]     key_mask;

    logic [NKEYS-1:0]     key_fall_c;
    logic                 dec_c;
    logic                 fire_c;
    logic [NPEND-1:0]     set_c;
    logic [NPEND-1:0]     ack_mask_c;
    logic [NPEND-1:0]     pending_nxt_c;

    arb_state_t           state;
    arb_state_t           state_nxt_c;
    logic [SEL_W-1:0]     sel;
    logic [SEL_W-1:0]     sel_nxt_c;
    logic [SEL_W-1:0]     pick_c;
    logic                 pick_valid_c;
    logic                 timer_int_nxt_c;
    logic                 op_int_nxt_c;
    logic [15:0]          int_pos_nxt_c;

    // Per-key synchronizer and falling-edge pulse.
    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_edge_sync u_sync (
            .clock   (clock),
            .n_reset (n_reset),
            .key_n   (keys_n[g]),
            .fall_c  (key_fall_c[g])
        );
    end

    // Configuration registers written by kernel code over the op/value bus.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            quantum   <= DEF_QUANTUM;
            timer_vec <= DEF_TIMER_VEC;
            key_vec   <= DEF_KEY_VEC;
            timer_en  <= 1'b0;
            key_mask  <= '1;
        end else if (cfg_en) begin
            case (cfg_op)
                CFG_SET_QUANTUM: quantum   <= QUANTUM_W'(cfg_value);
                CFG_SET_TVEC:    timer_vec <= cfg_value;
                CFG_SET_KVEC:    key_vec   <= cfg_value;
                CFG_TIMER_ON:    timer_en  <= 1'b1;
                CFG_TIMER_OFF:   timer_en  <= 1'b0;
                CFG_KEY_MASK:    key_mask  <= cfg_value[NKEYS-1:0];
                default:         ;
            endcase
        end
    end

    assign dec_c  = timer_en & ~kernel_mode & (quantum != '0);
    assign fire_c = dec_c & (counter == QUANTUM_W'(1));

    // Quantum counter: runs only in user mode; config writes take precedence.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            counter <= DEF_QUANTUM;
        end else if (cfg_en && (cfg_op == CFG_SET_QUANTUM)) begin
            counter <= QUANTUM_W'(cfg_value);
        end else if (cfg_en && (cfg_op == CFG_TIMER_ON)) begin
            counter <= quantum;
        end else if (dec_c) begin
            // A stray zero count reloads without firing.
            if (counter <= QUANTUM_W'(1)) begin
                counter <= quantum;
            end else begin
                counter <= counter - QUANTUM_W'(1);
            end
        end
    end

    assign set_c = {key_fall_c & ~key_mask, fire_c};

    // Pending update: clears first, then new events, so a same-cycle set wins.
    always_comb begin
        pending_nxt_c = pending;
        if (cfg_en && (cfg_op == CFG_CLR_PEND)) begin
            pending_nxt_c = pending_nxt_c & ~cfg_value[NKEYS:0];
        end
        pending_nxt_c = (pending_nxt_c & ~ack_mask_c) | set_c;
    end

    // Lowest set pending bit wins: timer first, then key0 upward.
    always_comb begin
        pick_valid_c = 1'b0;
        pick_c       = '0;
        for (int unsigned i = 0; i < NPEND; i++) begin
            if (!pick_valid_c && pending[i]) begin
                pick_valid_c = 1'b1;
                pick_c       = SEL_W'(i);
            end
        end
    end

    // Arbiter next-state and next-output logic.
    always_comb begin
        state_nxt_c     = state;
        sel_nxt_c       = sel;
        timer_int_nxt_c = timer_int;
        op_int_nxt_c    = op_int;
        int_pos_nxt_c   = int_pos;
        ack_mask_c      = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid_c && !kernel_mode) begin
                    sel_nxt_c   = pick_c;
                    state_nxt_c = ST_PRESENT;
                    if (pick_c == SEL_W'(PEND_TIMER)) begin
                        timer_int_nxt_c = 1'b1;
                        int_pos_nxt_c   = timer_vec;
                    end else begin
                        op_int_nxt_c  = 1'b1;
                        int_pos_nxt_c = key_vec + 16'(pick_c) - 16'(PEND_KEY0);
                    end
                end
            end
            ST_PRESENT: begin
                if (int_ack) begin
                    for (int unsigned i = 0; i < NPEND; i++) begin
                        if (sel == SEL_W'(i)) begin
                            ack_mask_c[i] = 1'b1;
                        end
                    end
                    timer_int_nxt_c = 1'b0;
                    op_int_nxt_c    = 1'b0;
                    int_pos_nxt_c   = '0;
                    state_nxt_c     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                state_nxt_c = ST_IDLE;
            end
            default: begin
                state_nxt_c     = ST_IDLE;
                timer_int_nxt_c = 1'b0;
                op_int_nxt_c    = 1'b0;
                int_pos_nxt_c   = '0;
            end
        endcase
    end

    // Arbiter state, selection and registered request outputs.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state     <= ST_IDLE;
            sel       <= '0;
            timer_int <= 1'b0;
            op_int    <= 1'b0;
            int_pos   <= '0;
            pending   <= '0;
        end else begin
            state     <= state_nxt_c;
            sel       <= sel_nxt_c;
            timer_int <= timer_int_nxt_c;
            op_int    <= op_int_nxt_c;
            int_pos   <= int_pos_nxt_c;
            pending   <= pending_nxt_c;
        end
    end

endmodule

// File: doc/irq_preempt_ctrl.md
Name: irq_preempt_ctrl

Overview:
- Interrupt and preemption controller upstream of the program counter and kernel-entry logic.
- Counts the user-mode time quantum and captures key-press events from the board keys.
- Prioritizes pending events and presents one interrupt at a time to the PC: timer_int or op_int, plus a vector in int_pos.
- Configured by kernel code through the scheduler-decoder op/value bus; runs on the CPU virtual clock.

Parameters:
- QUANTUM_W, 16, width of quantum counter and quantum register
- DEF_QUANTUM, 16'd1000, quantum loaded at reset
- DEF_TIMER_VEC, 16'h0010, reset value of timer vector
- DEF_KEY_VEC, 16'h0020, reset value of key vector base
- NKEYS, 4, number of key inputs

Ports:
- clock  in  1  CPU virtual clock, rising edge
- n_reset  in  1  asynchronous reset, active-low
- cfg_en  in  1  config strobe, one cycle; op applied at this edge
- cfg_op  in  4  config opcode
- cfg_value  in  16  config operand
- keys_n  in  NKEYS  raw board keys, active-low, asynchronous
- kernel_mode  in  1  high while CPU executes kernel code
- int_ack  in  1  PC has taken the presented interrupt
- timer_int  out  1  timer interrupt request
- op_int  out  1  key/event interrupt request
- int_pos  out  16  vector of the presented interrupt
- pending  out  NKEYS+1  pending bits; bit 0 is timer, bit i+1 is key i

Behaviour:
- Reset (async, n_reset low):
  - Outputs: timer_int=0, op_int=0, int_pos=0, pending=0.
  - Internal: quantum=DEF_QUANTUM, counter=DEF_QUANTUM, timer_en=0, key_mask=all ones (masked), vectors at defaults, FSM=IDLE, synchronizers=1.
  - Deasserting reset mid-operation restarts cleanly from these values.
- Config ops, applied when cfg_en=1; other opcodes are no-ops:
  - 0: NOP
  - 1: quantum=cfg_value and counter=cfg_value
  - 2: timer vector=cfg_value
  - 3: key vector base=cfg_value
  - 4: timer_en=1, counter reload
  - 5: timer_en=0
  - 6: key_mask=cfg_value[NKEYS-1:0] (1 = masked)
  - 7: pending &= ~cfg_value[NKEYS:0]
- Keys:
  - Each key uses a two-flop synchronizer followed by falling-edge detect: 1 cycle pulse, 3 cycles after the raw edge.
  - Unmasked pulse sets pending[i+1]. Masked pulses are dropped and not remembered.
  - Debounce is the caller's responsibility.
- Timer:
  - Counter decrements each cycle when timer_en=1, kernel_mode=0 and quantum!=0. It holds in kernel mode.
  - At counter==1 and decrementing: set pending[0] and reload counter=quantum next cycle.
  - quantum==0 means the timer never fires.
- Simultaneous events: a set from an event in the same cycle as op 7 clearing that bit leaves the bit set (set wins).
- Arbiter FSM, states IDLE, PRESENT, SETTLE:
  - IDLE: if pending!=0 and kernel_mode=0, select the lowest set bit (timer highest priority, then key0..key3).
    - Timer selected: next cycle timer_int=1, int_pos=timer vector.
    - Key i selected: next cycle op_int=1, int_pos=key base+i (16-bit wrap).
    - Go to PRESENT.
  - PRESENT: outputs held stable; selection frozen even if higher-priority bits arrive.
    - int_ack=1: clear the selected pending bit; drop timer_int, op_int and int_pos to 0 next cycle; go to SETTLE.
  - SETTLE: one cycle so kernel_mode can rise, then IDLE.
  - kernel_mode rising while in PRESENT does not withdraw the request.
  - int_ack outside PRESENT is ignored.
- Latency: pending set at edge N means request visible at edge N+1 (from IDLE, user mode).
- At most one of timer_int and op_int is high at any time.

Decomposition:
- Shared package irq_pkg holds:
  - config opcode constants (CFG_NOP..CFG_CLR_PEND)
  - FSM state encoding
  - pending bit index constants
- Sub-module key_edge_sync: per-key two-flop synchronizer and falling-edge pulse, instantiated NKEYS times.
- Counter, config decode and arbiter stay in the top module.

Test Plan:
- Reset, then op 1 value 5, op 4 -> timer_int=1 with int_pos=16'h0010 five cycles after the op 4 edge (+1 for the request); int_ack -> deasserts next cycle, pending[0]=0.
- Op 6 value 4'b1110, keys_n[0] pulses low, keys_n[1] pulses low -> only key0 accepted: op_int=1, int_pos=16'h0020, pending=5'b00010; key1 never pending.
- Timer fire and key0 edge land in the same cycle -> timer presented first; after ack+SETTLE, key0 presented with int_pos=16'h0020.
- kernel_mode=1 with timer enabled and quantum=3 for 20 cycles -> counter holds, no request; kernel_mode=0 -> fires 3 cycles later.
- Op 7 value 5'b00001 in the same cycle the timer sets pending[0] -> pending[0] remains 1.
- n_reset low while in PRESENT -> timer_int, op_int, int_pos and pending all 0 immediately, timer_en=0 after release.
